// File: rtl/insertion_arbiter_pkg.sv
// rtl/insertion_arbiter_pkg.sv - shared constants, FSM states and transaction layout for the insertion stage
package insertion_arbiter_pkg;

    localparam int PROGRAM_ID_W             = 64;
    localparam int DEFAULT_MAX_DEPENDENCIES = 256;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [PROGRAM_ID_W-1:0]             owner_programID;
        logic [DEFAULT_MAX_DEPENDENCIES-1:0] read_dependencies;
        logic [DEFAULT_MAX_DEPENDENCIES-1:0] write_dependencies;
    } insertion_txn_t;

endpackage

// File: rtl/insertion_arbiter_rr_pick.sv
// rtl/insertion_arbiter_rr_pick.sv - combinational round-robin priority encoder
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    int         cand;
    logic [W-1:0] cand_idx;

    // Search starts one past the last winner so it becomes lowest priority.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= N; i++) begin
            cand     = (int'(ptr) + i) % N;
            cand_idx = W'(cand);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/insertion_arbiter.sv
// rtl/insertion_arbiter.sv - round-robin burst arbiter feeding the insertion queue through one register stage
module insertion_arbiter
    import insertion_arbiter_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int MAX_DEPENDENCIES = DEFAULT_MAX_DEPENDENCIES,
    parameter int BURST_LEN        = 4,
    parameter int SRC_W            = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  s_axis_tvalid,
    output logic [NUM_REQ-1:0]                  s_axis_tready,
    input  logic [PROGRAM_ID_W*NUM_REQ-1:0]     s_axis_tdata_owner_programID,
    input  logic [MAX_DEPENDENCIES*NUM_REQ-1:0] s_axis_tdata_read_dependencies,
    input  logic [MAX_DEPENDENCIES*NUM_REQ-1:0] s_axis_tdata_write_dependencies,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [PROGRAM_ID_W-1:0]             m_axis_tdata_owner_programID,
    output logic [MAX_DEPENDENCIES-1:0]         m_axis_tdata_read_dependencies,
    output logic [MAX_DEPENDENCIES-1:0]         m_axis_tdata_write_dependencies,
    output logic [SRC_W-1:0]                    m_axis_tdata_source_id,
    output logic [31:0]                         grant_count,
    output logic [31:0]                         beat_count
);

    arb_state_t       state;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] pick_idx;
    logic             pick_found;
    logic [7:0]       burst_cnt;
    logic             out_free;
    logic             src_valid;
    logic             accept;
    logic             burst_done;

    assign out_free   = !m_axis_tvalid || m_axis_tready;
    assign src_valid  = s_axis_tvalid[grant_idx];
    assign accept     = (state == GRANT) && src_valid && out_free;
    assign burst_done = (burst_cnt + 8'd1) == 8'(BURST_LEN);

    rr_pick #(
        .N (NUM_REQ),
        .W (SRC_W)
    ) u_rr_pick (
        .req   (s_axis_tvalid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        s_axis_tready = '0;
        if (state == GRANT && out_free) begin
            s_axis_tready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_idx   <= '0;
            rr_ptr      <= SRC_W'(NUM_REQ - 1);
            burst_cnt   <= '0;
            grant_count <= '0;
            beat_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_idx <= pick_idx;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        burst_cnt  <= burst_cnt + 8'd1;
                        beat_count <= beat_count + 32'd1;
                    end
                    // A stalled output holds the grant; a dropped source or full burst releases it.
                    if (!src_valid || (out_free && burst_done)) begin
                        rr_ptr      <= grant_idx;
                        grant_count <= grant_count + 32'd1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid                   <= 1'b0;
            m_axis_tdata_owner_programID    <= '0;
            m_axis_tdata_read_dependencies  <= '0;
            m_axis_tdata_write_dependencies <= '0;
            m_axis_tdata_source_id          <= '0;
        end else if (accept) begin
            m_axis_tvalid                   <= 1'b1;
            m_axis_tdata_owner_programID    <= s_axis_tdata_owner_programID[PROGRAM_ID_W*grant_idx +: PROGRAM_ID_W];
            m_axis_tdata_read_dependencies  <= s_axis_tdata_read_dependencies[MAX_DEPENDENCIES*grant_idx +: MAX_DEPENDENCIES];
            m_axis_tdata_write_dependencies <= s_axis_tdata_write_dependencies[MAX_DEPENDENCIES*grant_idx +: MAX_DEPENDENCIES];
            m_axis_tdata_source_id          <= grant_idx;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_insertion_arbiter.sv
// tb/tb_insertion_arbiter.sv - randomized bench for insertion_arbiter against a transaction-level reference
module tb_insertion_arbiter;

    localparam int N  = 4;
    localparam int MD = 256;
    localparam int BL = 4;
    localparam int SW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     s_tvalid;
    logic [N-1:0]     s_tready;
    logic [64*N-1:0]  s_pid;
    logic [MD*N-1:0]  s_rd;
    logic [MD*N-1:0]  s_wr;
    logic             m_tvalid;
    logic             m_tready;
    logic [63:0]      m_pid;
    logic [MD-1:0]    m_rd;
    logic [MD-1:0]    m_wr;
    logic [SW-1:0]    m_src;
    logic [31:0]      gc;
    logic [31:0]      bc;

    logic [63:0]      pid [N];
    logic [MD-1:0]    rd  [N];
    logic [MD-1:0]    wr  [N];

    int               serving;
    int               served;
    int               last;
    logic             e_valid;
    logic [63:0]      e_pid;
    logic [MD-1:0]    e_rd;
    logic [MD-1:0]    e_wr;
    int               e_src;
    logic [31:0]      e_gc;
    logic [31:0]      e_bc;

    int               vectors;
    int               miscompares;

    always #5 clk = ~clk;

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign s_pid[64*i +: 64] = pid[i];
        assign s_rd[MD*i +: MD]  = rd[i];
        assign s_wr[MD*i +: MD]  = wr[i];
    end

    insertion_arbiter #(
        .NUM_REQ          (N),
        .MAX_DEPENDENCIES (MD),
        .BURST_LEN        (BL),
        .SRC_W            (SW)
    ) dut (
        .clk                             (clk),
        .rst_n                           (rst_n),
        .s_axis_tvalid                   (s_tvalid),
        .s_axis_tready                   (s_tready),
        .s_axis_tdata_owner_programID    (s_pid),
        .s_axis_tdata_read_dependencies  (s_rd),
        .s_axis_tdata_write_dependencies (s_wr),
        .m_axis_tvalid                   (m_tvalid),
        .m_axis_tready                   (m_tready),
        .m_axis_tdata_owner_programID    (m_pid),
        .m_axis_tdata_read_dependencies  (m_rd),
        .m_axis_tdata_write_dependencies (m_wr),
        .m_axis_tdata_source_id          (m_src),
        .grant_count                     (gc),
        .beat_count                      (bc)
    );

    task automatic check(input string tag, input logic [MD-1:0] got, input logic [MD-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        serving = -1;
        served  = 0;
        last    = N - 1;
        e_valid = 1'b0;
        e_pid   = '0;
        e_rd    = '0;
        e_wr    = '0;
        e_src   = 0;
        e_gc    = '0;
        e_bc    = '0;
    endtask

    task automatic check_outputs();
        check("m_tvalid", MD'(m_tvalid), MD'(e_valid));
        if (e_valid) begin
            check("m_pid", MD'(m_pid), MD'(e_pid));
            check("m_rd", m_rd, e_rd);
            check("m_wr", m_wr, e_wr);
            check("m_src", MD'(m_src), MD'(e_src));
        end
        check("grant_count", MD'(gc), MD'(e_gc));
        check("beat_count", MD'(bc), MD'(e_bc));
    endtask

    task automatic release_grant();
        last    = serving;
        serving = -1;
        e_gc    = e_gc + 32'd1;
    endtask

    // One clock: check registered state, apply new inputs, predict ready, then advance the reference.
    task automatic cycle(input logic [N-1:0] v, input logic mr);
        logic         ofree;
        logic [N-1:0] exp_rdy;
        logic         hit;
        int           g;
        @(negedge clk);
        check_outputs();
        for (int i = 0; i < N; i++) begin
            pid[i] = {$urandom(), $urandom()};
            for (int k = 0; k < MD/32; k++) begin
                rd[i][32*k +: 32] = $urandom();
                wr[i][32*k +: 32] = $urandom();
            end
        end
        s_tvalid = v;
        m_tready = mr;
        #1;
        ofree   = !e_valid || mr;
        exp_rdy = '0;
        if (serving >= 0 && ofree) exp_rdy[serving] = 1'b1;
        check("s_tready", MD'(s_tready), MD'(exp_rdy));
        if (serving < 0) begin
            if (e_valid && mr) e_valid = 1'b0;
            hit = 1'b0;
            for (int k = 1; k <= N; k++) begin
                g = (last + k) % N;
                if (!hit && v[g]) begin
                    hit     = 1'b1;
                    serving = g;
                    served  = 0;
                end
            end
        end else if (v[serving] && ofree) begin
            e_valid = 1'b1;
            e_pid   = pid[serving];
            e_rd    = rd[serving];
            e_wr    = wr[serving];
            e_src   = serving;
            e_bc    = e_bc + 32'd1;
            served++;
            if (served == BL) release_grant();
        end else begin
            if (e_valid && mr) e_valid = 1'b0;
            if (!v[serving]) release_grant();
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        s_tvalid = '0;
        #1;
        check("rst_m_tvalid", MD'(m_tvalid), '0);
        check("rst_s_tready", MD'(s_tready), '0);
        check("rst_grant_count", MD'(gc), '0);
        check("rst_beat_count", MD'(bc), '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] hold_v;
        vectors     = 0;
        miscompares = 0;
        s_tvalid    = '0;
        m_tready    = 1'b0;
        for (int i = 0; i < N; i++) begin
            pid[i] = '0;
            rd[i]  = '0;
            wr[i]  = '0;
        end
        model_reset();

        repeat (3) @(negedge clk);
        check_outputs();
        check("reset_s_tready", MD'(s_tready), '0);
        check("reset_m_pid", MD'(m_pid), '0);
        check("reset_m_rd", m_rd, '0);
        check("reset_m_wr", m_wr, '0);
        check("reset_m_src", MD'(m_src), '0);
        rst_n = 1'b1;

        // Reset leaves the pointer at the top index, so source 0 must win the wrap-around.
        repeat (2) cycle(4'b1001, 1'b1);
        @(posedge clk);
        #1;
        check("wrap_first_valid", MD'(m_tvalid), MD'(1'b1));
        check("wrap_first_src", MD'(m_src), '0);
        repeat (14) cycle(4'b1001, 1'b1);

        repeat (3) cycle(4'b0010, 1'b1);
        async_reset();

        repeat (8) cycle(4'b0001, 1'b1);
        repeat (2) cycle(4'b0000, 1'b1);
        @(posedge clk);
        #1;
        check("single_src_grants", MD'(gc), MD'(32'd2));
        check("single_src_beats", MD'(bc), MD'(32'd6));

        repeat (20) cycle(4'b0110, 1'b1);

        repeat (3) cycle(4'b0100, 1'b1);
        repeat (5) cycle(4'b0100, 1'b0);
        repeat (4) cycle(4'b0100, 1'b1);
        repeat (2) cycle(4'b0000, 1'b1);

        repeat (3) cycle(4'b0100, 1'b1);
        repeat (4) cycle(4'b0010, 1'b1);

        for (int ph = 0; ph < 4; ph++) begin
            hold_v = N'($urandom());
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(0, 7) == 0) hold_v = N'($urandom());
                if (ph[0]) cycle(N'($urandom()), ($urandom_range(0, 3) != 0));
                else       cycle(hold_v, ($urandom_range(0, 4) != 0));
            end
            async_reset();
        end
        cycle('0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
